// File: rtl/codeword_event_logger_if.sv
// Event stream from the logger to its consumer: head-of-FIFO timestamp with a
// valid/ready handshake.
interface codeword_event_logger_if #(
    parameter int unsigned TS_WIDTH = 16
);
    logic                evt_valid;
    logic                evt_ready;
    logic [TS_WIDTH-1:0] evt_timestamp;

    modport master (
        output evt_valid,
        output evt_timestamp,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_timestamp,
        output evt_ready
    );
endinterface

// File: rtl/codeword_event_logger.sv
// Timestamps qualified codeword detections into a small FIFO drained over a
// valid/ready stream, with a saturating detection count and sticky overflow.
module codeword_event_logger #(
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seq_detect,
    input  logic                       clear,
    codeword_event_logger_if.master    evt,
    output logic [CNT_WIDTH-1:0]       evt_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       fifo_full,
    output logic                       overflow
);

    // DEPTH must be a power of two so the extra pointer bit marks a lap.
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic                prev_detect;
    logic                qual;
    logic                do_pop;
    logic                do_push;
    logic                drop;

    assign qual       = (EDGE_MODE != 0) ? (seq_detect & ~prev_detect) : seq_detect;
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == FULL_LEVEL);

    assign evt.evt_valid     = (fifo_level != '0);
    assign evt.evt_timestamp = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot this cycle, so a full FIFO can still accept a push.
    assign do_pop  = evt.evt_valid & evt.evt_ready;
    assign do_push = qual & (~fifo_full | do_pop);
    assign drop    = qual & fifo_full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt      <= '0;
            prev_detect <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            evt_count   <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            ts_cnt      <= '0;
            prev_detect <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            evt_count   <= '0;
            overflow    <= 1'b0;
        end else begin
            ts_cnt      <= ts_cnt + 1'b1;
            prev_detect <= seq_detect;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (qual && (evt_count != '1)) begin
                evt_count <= evt_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= ts_cnt;
        end
    end

endmodule

// File: tb/tb_codeword_event_logger.sv
// Scoreboard bench: two logger instances (edge-qualified 16-bit stamps, and
// level-qualified 4-bit stamps with a 2-bit counter).
module tb_codeword_event_logger;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seq_a = 1'b0;
    logic seq_b = 1'b0;
    logic clear = 1'b0;

    logic [15:0] count_a;
    logic [3:0]  level_a;
    logic        full_a;
    logic        ovf_a;
    logic [1:0]  count_b;
    logic [3:0]  level_b;
    logic        full_b;
    logic        ovf_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_a[$];
    int exp_b[$];

    always #5 clk = ~clk;

    codeword_event_logger_if #(.TS_WIDTH(16)) if_a ();
    codeword_event_logger_if #(.TS_WIDTH(4))  if_b ();

    codeword_event_logger #(
        .TS_WIDTH(16), .DEPTH(8), .CNT_WIDTH(16), .EDGE_MODE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .seq_detect(seq_a), .clear(clear),
        .evt(if_a), .evt_count(count_a), .fifo_level(level_a),
        .fifo_full(full_a), .overflow(ovf_a)
    );

    codeword_event_logger #(
        .TS_WIDTH(4), .DEPTH(8), .CNT_WIDTH(2), .EDGE_MODE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .seq_detect(seq_b), .clear(clear),
        .evt(if_b), .evt_count(count_b), .fifo_level(level_b),
        .fifo_full(full_b), .overflow(ovf_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sa, input logic sb,
                                 input logic ra, input logic rb, input logic clr);
        seq_a          = sa;
        seq_b          = sb;
        if_a.evt_ready = ra;
        if_b.evt_ready = rb;
        clear          = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Handshakes are judged at the falling edge, ahead of the popping rising edge.
    always @(negedge clk) begin : mon_a
        int e;
        if (rst_n && if_a.evt_valid && if_a.evt_ready) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = exp_a.pop_front();
                checkOutput("a_pop_stamp", 32'(if_a.evt_timestamp), e);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int e;
        if (rst_n && if_b.evt_valid && if_b.evt_ready) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = exp_b.pop_front();
                checkOutput("b_pop_stamp", 32'(if_b.evt_timestamp), e);
            end
        end
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_a_valid", 32'(if_a.evt_valid), 0);
        checkOutput("rst_a_stamp", 32'(if_a.evt_timestamp), 0);
        checkOutput("rst_a_count", 32'(count_a), 0);
        checkOutput("rst_a_level", 32'(level_a), 0);
        checkOutput("rst_a_full", 32'(full_a), 0);
        checkOutput("rst_a_ovf", 32'(ovf_a), 0);
        checkOutput("rst_b_valid", 32'(if_b.evt_valid), 0);
        checkOutput("rst_b_count", 32'(count_b), 0);

        rst_n = 1'b1;
        cyc   = 0;

        // b: single pulse at 17 wraps the 4-bit stamp to 1.
        run_to(17);
        seq_b = 1'b1; exp_b.push_back(1);
        tick();
        seq_b = 1'b0;

        run_to(20);
        seq_a = 1'b1; exp_a.push_back(20);
        tick();
        seq_a = 1'b0;
        checkOutput("a_first_valid", 32'(if_a.evt_valid), 1);
        checkOutput("a_first_stamp", 32'(if_a.evt_timestamp), 20);
        checkOutput("a_first_count", 32'(count_a), 1);
        checkOutput("a_first_level", 32'(level_a), 1);
        checkOutput("b_first_valid", 32'(if_b.evt_valid), 1);
        checkOutput("b_first_count", 32'(count_b), 1);
        run_to(29);
        checkOutput("a_hold_stamp", 32'(if_a.evt_timestamp), 20);

        // Held high for 5 cycles: one edge on a, five levels on b.
        run_to(30);
        seq_a = 1'b1; seq_b = 1'b1;
        exp_a.push_back(30);
        exp_b.push_back(14); exp_b.push_back(15); exp_b.push_back(0);
        exp_b.push_back(1);  exp_b.push_back(2);
        run_to(35);
        seq_a = 1'b0; seq_b = 1'b0;
        checkOutput("a_edge_count", 32'(count_a), 2);
        checkOutput("a_edge_level", 32'(level_a), 2);
        checkOutput("b_level_count_sat", 32'(count_b), 3);
        checkOutput("b_level_level", 32'(level_b), 6);

        applyStimulus(0, 0, 1, 1, 0);
        run_to(45);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("a_drain_valid", 32'(if_a.evt_valid), 0);
        checkOutput("a_drain_level", 32'(level_a), 0);
        checkOutput("b_drain_valid", 32'(if_b.evt_valid), 0);
        checkOutput("b_drain_level", 32'(level_b), 0);
        checkOutput("a_queue_drained", 32'(exp_a.size()), 0);
        checkOutput("b_queue_drained", 32'(exp_b.size()), 0);

        // Fill, push-while-popping at full, then overflow.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc = 0;
        checkOutput("clr_a_count", 32'(count_a), 0);
        checkOutput("clr_a_level", 32'(level_a), 0);
        for (int i = 1; i <= 8; i++) begin
            run_to(2 * i);
            seq_a = 1'b1; exp_a.push_back(2 * i);
            tick();
            seq_a = 1'b0;
        end
        checkOutput("fill_full", 32'(full_a), 1);
        checkOutput("fill_level", 32'(level_a), 8);
        checkOutput("fill_ovf", 32'(ovf_a), 0);
        checkOutput("fill_count", 32'(count_a), 8);

        run_to(20);
        seq_a = 1'b1; if_a.evt_ready = 1'b1; exp_a.push_back(20);
        tick();
        seq_a = 1'b0; if_a.evt_ready = 1'b0;
        checkOutput("swap_level", 32'(level_a), 8);
        checkOutput("swap_full", 32'(full_a), 1);
        checkOutput("swap_ovf", 32'(ovf_a), 0);
        checkOutput("swap_count", 32'(count_a), 9);

        run_to(22);
        seq_a = 1'b1;
        tick();
        seq_a = 1'b0;
        checkOutput("drop_ovf", 32'(ovf_a), 1);
        checkOutput("drop_count", 32'(count_a), 10);
        checkOutput("drop_level", 32'(level_a), 8);

        if_a.evt_ready = 1'b1;
        run_to(33);
        if_a.evt_ready = 1'b0;
        checkOutput("ovf_drain_valid", 32'(if_a.evt_valid), 0);
        checkOutput("ovf_drain_level", 32'(level_a), 0);
        checkOutput("ovf_sticky", 32'(ovf_a), 1);
        checkOutput("ovf_queue_drained", 32'(exp_a.size()), 0);

        // Clear with three entries held and a detection in the same cycle.
        for (int i = 0; i < 3; i++) begin
            run_to(40 + 2 * i);
            seq_a = 1'b1; exp_a.push_back(40 + 2 * i);
            tick();
            seq_a = 1'b0;
        end
        run_to(46);
        checkOutput("pre_clear_level", 32'(level_a), 3);
        seq_a = 1'b1; clear = 1'b1;
        tick();
        seq_a = 1'b0; clear = 1'b0;
        exp_a.delete();
        exp_b.delete();
        cyc = 0;
        checkOutput("clear_level", 32'(level_a), 0);
        checkOutput("clear_valid", 32'(if_a.evt_valid), 0);
        checkOutput("clear_count", 32'(count_a), 0);
        checkOutput("clear_ovf", 32'(ovf_a), 0);
        run_to(3);
        seq_a = 1'b1; exp_a.push_back(3);
        tick();
        seq_a = 1'b0;
        checkOutput("restart_stamp", 32'(if_a.evt_timestamp), 3);
        checkOutput("restart_count", 32'(count_a), 1);

        // Asynchronous reset between clock edges.
        run_to(5);
        seq_b = 1'b1; exp_b.push_back(5);
        tick();
        seq_b = 1'b0;
        tick();
        checkOutput("pre_rst_b_valid", 32'(if_b.evt_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_a_valid", 32'(if_a.evt_valid), 0);
        checkOutput("arst_a_stamp", 32'(if_a.evt_timestamp), 0);
        checkOutput("arst_a_count", 32'(count_a), 0);
        checkOutput("arst_a_level", 32'(level_a), 0);
        checkOutput("arst_b_valid", 32'(if_b.evt_valid), 0);
        checkOutput("arst_b_count", 32'(count_b), 0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("post_rst_a_valid", 32'(if_a.evt_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
